// File: rtl/adc_decimator.sv
// Boxcar decimator for SAR ADC results: edge-detects conversions, averages
// 2**LOG2_AVG samples and streams the averages out through a small FIFO.
module adc_decimator #(
  parameter int unsigned RESOLUTION = 8,
  parameter int unsigned LOG2_AVG   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic                          clear_i,
  input  logic                          adc_rdy_i,
  input  logic [RESOLUTION-1:0]         adc_result_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [RESOLUTION-1:0]         out_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o
);

  localparam int unsigned ACC_W = RESOLUTION + LOG2_AVG;
  localparam int unsigned CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  typedef enum logic {
    ST_IDLE,
    ST_ACCUM
  } state_e;

  state_e              r_state, w_state_d;
  logic                r_rdy_prev;
  logic [ACC_W-1:0]    r_acc, w_acc_d, w_sum;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic                w_evt, w_push_req;
  logic [RESOLUTION-1:0] w_word;

  logic [RESOLUTION-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr, w_rd_ptr_d;
  logic [LVL_W-1:0]    r_level, w_level_after_pop, w_level_d;
  logic                r_valid, r_ovf;
  logic [RESOLUTION-1:0] r_data, w_head_d;
  logic                w_full, w_pop, w_push, w_drop;

  // A level already high when en_i rises never counts as a sample
  assign w_evt  = adc_rdy_i & ~r_rdy_prev & en_i;
  assign w_sum  = r_acc + ACC_W'(adc_result_i);
  assign w_word = RESOLUTION'(w_sum >> LOG2_AVG);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_rdy_prev <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_rdy_prev <= adc_rdy_i;
      r_acc      <= w_acc_d;
      r_cnt      <= w_cnt_d;
    end
  end

  // Window sequencing; leaving ACCUM discards any partial window
  always_comb begin
    w_state_d  = r_state;
    w_acc_d    = r_acc;
    w_cnt_d    = r_cnt;
    w_push_req = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_acc_d = '0;
        w_cnt_d = '0;
        if (en_i) w_state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (!en_i) begin
          w_state_d = ST_IDLE;
          w_acc_d   = '0;
          w_cnt_d   = '0;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
    if (w_evt) begin
      if (r_cnt == CNT_LAST) begin
        w_push_req = 1'b1;
        w_acc_d    = '0;
        w_cnt_d    = '0;
      end else begin
        w_acc_d = w_sum;
        w_cnt_d = r_cnt + CNT_W'(1);
      end
    end
    if (clear_i) begin
      w_acc_d    = '0;
      w_cnt_d    = '0;
      w_push_req = 1'b0;
    end
  end

  // A pop frees the slot, so a push into a full FIFO is accepted alongside it
  assign w_full            = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop             = r_valid & out_ready_i & ~clear_i;
  assign w_push            = w_push_req & (~w_full | w_pop);
  assign w_drop            = w_push_req & w_full & ~w_pop;
  assign w_level_after_pop = r_level - LVL_W'(w_pop);
  assign w_level_d         = w_level_after_pop + LVL_W'(w_push);
  assign w_rd_ptr_d        = r_rd_ptr + PTR_W'(w_pop);

  // Next head word: bypass the incoming word when it lands in an empty FIFO
  always_comb begin
    w_head_d = '0;
    if (w_level_d != '0) begin
      if (w_push && (w_level_after_pop == '0)) w_head_d = w_word;
      else                                     w_head_d = r_mem[w_rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_ovf    <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
      r_rd_ptr <= w_rd_ptr_d;
      r_level  <= w_level_d;
      r_valid  <= (w_level_d != '0);
      r_data   <= w_head_d;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign out_valid_o  = r_valid;
  assign out_data_o   = r_data;
  assign fifo_level_o = r_level;
  assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_adc_decimator.sv
// Randomized and directed bench for adc_decimator: one averaging instance
// (LOG2_AVG=2) and one pass-through instance (LOG2_AVG=0) against a queue-level model.
module tb_adc_decimator;

  localparam int RES   = 8;
  localparam int DEPTH = 4;

  logic           clk_i;
  logic           rst_ni;
  logic           en_i;
  logic           clear_i;
  logic           adc_rdy_i;
  logic [RES-1:0] adc_result_i;
  logic           out_ready_i;

  logic           valid_a, valid_p;
  logic [RES-1:0] data_a, data_p;
  logic [2:0]     level_a, level_p;
  logic           ovf_a, ovf_p;

  int errors = 0;
  int checks = 0;

  adc_decimator #(.RESOLUTION(RES), .LOG2_AVG(2), .FIFO_DEPTH(DEPTH)) u_dut_avg (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .clear_i(clear_i),
    .adc_rdy_i(adc_rdy_i), .adc_result_i(adc_result_i),
    .out_valid_o(valid_a), .out_ready_i(out_ready_i), .out_data_o(data_a),
    .fifo_level_o(level_a), .overflow_o(ovf_a)
  );

  adc_decimator #(.RESOLUTION(RES), .LOG2_AVG(0), .FIFO_DEPTH(DEPTH)) u_dut_pass (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .clear_i(clear_i),
    .adc_rdy_i(adc_rdy_i), .adc_result_i(adc_result_i),
    .out_valid_o(valid_p), .out_ready_i(out_ready_i), .out_data_o(data_p),
    .fifo_level_o(level_p), .overflow_o(ovf_p)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model; index 0 = averaging instance, 1 = pass-through
  int m_sum  [2];
  int m_cnt  [2];
  int m_n    [2];
  int m_fifo [2][DEPTH];
  bit m_ovf  [2];
  bit m_prev;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sum[k] = 0; m_cnt[k] = 0; m_n[k] = 0; m_ovf[k] = 1'b0;
    end
    m_prev = 1'b0;
  endtask

  task automatic model_step();
    bit evt;
    evt = adc_rdy_i && !m_prev && en_i;
    for (int k = 0; k < 2; k++) begin
      int  navg;
      int  word;
      bit  pop;
      bit  push;
      navg = (k == 0) ? 4 : 1;
      word = 0;
      push = 1'b0;
      pop  = (m_n[k] > 0) && out_ready_i;
      if (clear_i) begin
        m_sum[k] = 0; m_cnt[k] = 0; m_n[k] = 0; m_ovf[k] = 1'b0;
      end else begin
        if (!en_i) begin
          m_sum[k] = 0; m_cnt[k] = 0;
        end else if (evt) begin
          m_sum[k] += int'(adc_result_i);
          m_cnt[k]++;
          if (m_cnt[k] == navg) begin
            word = m_sum[k] / navg;
            push = 1'b1;
            m_sum[k] = 0; m_cnt[k] = 0;
          end
        end
        if (push && (m_n[k] == DEPTH) && !pop) begin
          m_ovf[k] = 1'b1;
        end else begin
          if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) m_fifo[k][i] = m_fifo[k][i+1];
            m_n[k]--;
          end
          if (push) begin
            m_fifo[k][m_n[k]] = word;
            m_n[k]++;
          end
        end
      end
    end
    m_prev = adc_rdy_i;
  endtask

  task automatic compare_all();
    chk("avg_valid", int'(valid_a), int'(m_n[0] > 0));
    chk("avg_data",  int'(data_a),  (m_n[0] > 0) ? m_fifo[0][0] : 0);
    chk("avg_level", int'(level_a), m_n[0]);
    chk("avg_ovf",   int'(ovf_a),   int'(m_ovf[0]));
    chk("pass_valid", int'(valid_p), int'(m_n[1] > 0));
    chk("pass_data",  int'(data_p),  (m_n[1] > 0) ? m_fifo[1][0] : 0);
    chk("pass_level", int'(level_p), m_n[1]);
    chk("pass_ovf",   int'(ovf_p),   int'(m_ovf[1]));
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic edge_hi(input int v);
    adc_rdy_i = 1'b1;
    adc_result_i = RES'(v);
    tick();
  endtask

  task automatic edge_lo();
    adc_rdy_i = 1'b0;
    tick();
  endtask

  task automatic sample(input int v);
    edge_hi(v);
    edge_lo();
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_avg_valid"}, int'(valid_a), 0);
    chk({tag, "_avg_data"},  int'(data_a),  0);
    chk({tag, "_avg_level"}, int'(level_a), 0);
    chk({tag, "_avg_ovf"},   int'(ovf_a),   0);
    chk({tag, "_pass_level"}, int'(level_p), 0);
    chk({tag, "_pass_ovf"},   int'(ovf_p),   0);
  endtask

  initial begin
    rst_ni = 1'b0; en_i = 1'b0; clear_i = 1'b0;
    adc_rdy_i = 1'b0; adc_result_i = '0; out_ready_i = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    rst_ni = 1'b1;
    en_i = 1'b1;
    tick();

    // 1: four samples average to 25, visible right after the fourth edge
    sample(10); sample(20); sample(30);
    chk("t1_before", int'(valid_a), 0);
    edge_hi(41);
    chk("t1_valid", int'(valid_a), 1);
    chk("t1_data",  int'(data_a), 25);
    edge_lo();

    // 2: a held-high ready level counts once
    do_clear();
    edge_hi(8);
    repeat (20) tick();
    edge_lo();
    sample(8); sample(8);
    chk("t2_not_yet", int'(valid_a), 0);
    edge_hi(8);
    chk("t2_valid", int'(valid_a), 1);
    chk("t2_data",  int'(data_a), 8);
    edge_lo();

    // 3: pass-through overflow and drain
    do_clear();
    for (int v = 1; v <= 5; v++) sample(v);
    chk("t3_level", int'(level_p), 4);
    chk("t3_ovf",   int'(ovf_p), 1);
    out_ready_i = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      chk("t3_drain", int'(data_p), v);
      tick();
    end
    chk("t3_empty", int'(valid_p), 0);
    tick();
    chk("t3_empty_pop", int'(level_p), 0);
    chk("t3_ovf_sticky", int'(ovf_p), 1);
    out_ready_i = 1'b0;

    // 4: push and pop on a full FIFO in the same cycle
    do_clear();
    for (int v = 1; v <= 4; v++) sample(v);
    out_ready_i = 1'b1;
    edge_hi(9);
    chk("t4_level", int'(level_p), 4);
    chk("t4_ovf",   int'(ovf_p), 0);
    chk("t4_head",  int'(data_p), 2);
    out_ready_i = 1'b0;
    edge_lo();

    // 5: level high at enable is ignored; disabling discards a partial window
    do_clear();
    en_i = 1'b0;
    edge_hi(77);
    en_i = 1'b1;
    tick(); tick();
    edge_lo();
    chk("t5_hold_high", int'(level_p), 0);
    sample(50); sample(50);
    en_i = 1'b0;
    tick();
    en_i = 1'b1;
    for (int i = 0; i < 4; i++) sample(100);
    chk("t5_data",  int'(data_a), 100);
    chk("t5_level", int'(level_a), 1);

    // 6: clear with queued words and a partial window, then async reset
    do_clear();
    for (int i = 0; i < 13; i++) sample(12);
    chk("t6_queued", int'(level_a), 3);
    clear_i = 1'b1;
    edge_hi(99);
    clear_i = 1'b0;
    check_all_zero("t6_clear");
    edge_lo();
    sample(200);
    rst_ni = 1'b0;
    #2;
    check_all_zero("t6_rst");
    model_reset();
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) sample(40);
    chk("t6_fresh", int'(data_a), 40);
    chk("t6_fresh_level", int'(level_a), 1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      en_i         = ($urandom_range(0, 15) != 0);
      clear_i      = ($urandom_range(0, 63) == 0);
      adc_rdy_i    = ($urandom_range(0, 1) == 1);
      adc_result_i = RES'($urandom_range(0, 255));
      out_ready_i  = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
